// File: rtl/lane_merge2_if.sv
// Handshake bundle for lane_merge2: two input lanes, one merged output,
// and the per-lane FIFO status flags.
interface lane_merge2_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data_in0;
    logic             valid_in0;
    logic [WIDTH-1:0] data_in1;
    logic             valid_in1;
    logic             ready_in;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             full0;
    logic             full1;
    logic             empty0;
    logic             empty1;
    logic             overflow;

    // Producer/consumer side: drives the lanes and the downstream ready.
    modport master (
        output data_in0, valid_in0, data_in1, valid_in1, ready_in,
        input  data_out, valid_out, full0, full1, empty0, empty1, overflow
    );

    // Merge block side.
    modport slave (
        input  data_in0, valid_in0, data_in1, valid_in1, ready_in,
        output data_out, valid_out, full0, full1, empty0, empty1, overflow
    );
endinterface

// File: rtl/lane_merge2.sv
// Two-lane merge: each lane is buffered in its own small FIFO, and a
// round-robin arbiter drains them into a registered valid/ready output.
// Order within a lane is preserved; when both lanes hold data they alternate.
module lane_merge2 #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int ADDR  = 2
) (
    input  logic          clk,
    input  logic          reset_L,
    lane_merge2_if.slave  bus
);
    localparam logic [ADDR:0]   CNT_ONE  = (ADDR+1)'(1);
    localparam logic [ADDR:0]   CNT_FULL = (ADDR+1)'(DEPTH);
    localparam logic [ADDR-1:0] PTR_ONE  = ADDR'(1);

    logic [WIDTH-1:0] mem     [2][DEPTH];
    logic [ADDR-1:0]  wr_ptr  [2];
    logic [ADDR-1:0]  rd_ptr  [2];
    logic [ADDR:0]    count   [2];
    logic [WIDTH-1:0] data_in [2];

    logic [1:0]       valid_in;
    logic [1:0]       full;
    logic [1:0]       empty;
    logic [1:0]       wr_en;
    logic [1:0]       rd_en;
    logic             load;
    logic             sel;
    logic [WIDTH-1:0] head;

    logic [WIDTH-1:0] data_out_q;
    logic             valid_out_q;
    logic             overflow_q;
    logic             last_lane;

    assign data_in[0] = bus.data_in0;
    assign data_in[1] = bus.data_in1;
    assign valid_in   = {bus.valid_in1, bus.valid_in0};

    // Status flags, write enables and arbitration for this cycle.
    // Fullness is taken from the registered count, so a full lane drops its
    // incoming word even when that lane is being read on the same edge.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            empty[k] = (count[k] == '0);
            full[k]  = (count[k] == CNT_FULL);
        end
        wr_en = valid_in & ~full;
        load  = (!valid_out_q || bus.ready_in) && (!empty[0] || !empty[1]);

        if (!empty[0] && !empty[1]) begin
            sel = ~last_lane;
        end else if (!empty[0]) begin
            sel = 1'b0;
        end else begin
            sel = 1'b1;
        end

        rd_en = 2'b00;
        if (load) begin
            rd_en[sel] = 1'b1;
        end
        head = mem[sel][rd_ptr[sel]];
    end

    // FIFO storage; contents need no reset because pointers/counts gate them.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (wr_en[k]) begin
                mem[k][wr_ptr[k]] <= data_in[k];
            end
        end
    end

    // Per-lane pointers and occupancy counts.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                count[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (wr_en[k]) begin
                    wr_ptr[k] <= wr_ptr[k] + PTR_ONE;
                end
                if (rd_en[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + PTR_ONE;
                end
                case ({wr_en[k], rd_en[k]})
                    2'b10:   count[k] <= count[k] + CNT_ONE;
                    2'b01:   count[k] <= count[k] - CNT_ONE;
                    default: count[k] <= count[k];
                endcase
            end
        end
    end

    // Output register, round-robin pointer and sticky overflow flag.
    // last_lane resets to 1 so lane 0 wins the first contested read.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            last_lane   <= 1'b1;
        end else begin
            if (load) begin
                data_out_q  <= head;
                valid_out_q <= 1'b1;
                last_lane   <= sel;
            end else if (bus.ready_in) begin
                valid_out_q <= 1'b0;
            end
            if (|(valid_in & full)) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_out_q;
    assign bus.overflow  = overflow_q;
    assign bus.full0     = full[0];
    assign bus.full1     = full[1];
    assign bus.empty0    = empty[0];
    assign bus.empty1    = empty[1];

endmodule

// File: tb/tb_lane_merge2.sv
// Directed bench for lane_merge2: inputs change 1 time unit after each rising
// edge, and outputs are checked at that same point (state after the edge).
module tb_lane_merge2;
    logic clk = 1'b0;
    logic reset_L;
    int   total = 0;
    int   bad   = 0;

    lane_merge2_if #(.WIDTH(4)) bus ();

    lane_merge2 #(.WIDTH(4), .DEPTH(4), .ADDR(2)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [3:0] d0,
                         input logic v1, input logic [3:0] d1, input logic rdy);
        bus.valid_in0 = v0;
        bus.data_in0  = d0;
        bus.valid_in1 = v1;
        bus.data_in1  = d1;
        bus.ready_in  = rdy;
    endtask

    initial begin
        // Reset then idle
        reset_L = 1'b0;
        drive(0, 4'h0, 0, 4'h0, 0);
        #1;
        chk("rst_valid", bus.valid_out, 0);
        chk("rst_data", bus.data_out, 0);
        chk("rst_empty", {bus.empty1, bus.empty0}, 2'b11);
        chk("rst_full", {bus.full1, bus.full0}, 2'b00);
        chk("rst_ovf", bus.overflow, 0);
        tick();
        tick();
        reset_L = 1'b1;
        tick();
        tick();
        chk("idle_valid", bus.valid_out, 0);
        chk("idle_data", bus.data_out, 0);
        chk("idle_empty", {bus.empty1, bus.empty0}, 2'b11);
        chk("idle_ovf", bus.overflow, 0);

        // Alternating merge
        drive(1, 4'h1, 1, 4'h2, 1);
        tick();
        chk("alt_lat", bus.valid_out, 0);
        drive(1, 4'h3, 1, 4'h4, 1);
        tick();
        chk("alt_w1", {bus.valid_out, bus.data_out}, 8'h11);
        drive(1, 4'h5, 1, 4'h6, 1);
        tick();
        chk("alt_w2", {bus.valid_out, bus.data_out}, 8'h12);
        drive(0, 4'h0, 0, 4'h0, 1);
        tick();
        chk("alt_w3", {bus.valid_out, bus.data_out}, 8'h13);
        tick();
        chk("alt_w4", {bus.valid_out, bus.data_out}, 8'h14);
        tick();
        chk("alt_w5", {bus.valid_out, bus.data_out}, 8'h15);
        tick();
        chk("alt_w6", {bus.valid_out, bus.data_out}, 8'h16);
        tick();
        chk("alt_drain", {bus.valid_out, bus.data_out}, 8'h06);

        // Single lane (lane1 only)
        drive(0, 4'h0, 1, 4'hF, 1);
        tick();
        drive(0, 4'h0, 1, 4'h6, 1);
        tick();
        chk("one_w1", {bus.valid_out, bus.data_out}, 8'h1F);
        drive(0, 4'h0, 1, 4'h8, 1);
        tick();
        chk("one_w2", {bus.valid_out, bus.data_out}, 8'h16);
        drive(0, 4'h0, 0, 4'h0, 1);
        tick();
        chk("one_w3", {bus.valid_out, bus.data_out}, 8'h18);
        tick();
        chk("one_drain", bus.valid_out, 0);
        chk("one_empty", {bus.empty1, bus.empty0}, 2'b11);

        // Back-pressure and overflow
        drive(1, 4'hA, 0, 4'h0, 1);
        tick();
        drive(0, 4'h0, 0, 4'h0, 0);
        tick();
        chk("bp_hold", {bus.valid_out, bus.data_out}, 8'h1A);
        for (int i = 1; i <= 4; i++) begin
            drive(1, 4'(i), 0, 4'h0, 0);
            tick();
        end
        chk("bp_full", bus.full0, 1);
        chk("bp_noovf", bus.overflow, 0);
        drive(1, 4'h5, 0, 4'h0, 0);
        tick();
        chk("bp_ovf", bus.overflow, 1);
        chk("bp_still", {bus.valid_out, bus.data_out}, 8'h1A);
        drive(0, 4'h0, 0, 4'h0, 1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("bp_drain", {bus.valid_out, bus.data_out}, 8'(8'h10 + i));
        end
        tick();
        chk("bp_end", bus.valid_out, 0);
        chk("bp_empty0", bus.empty0, 1);
        chk("bp_ovf_sticky", bus.overflow, 1);

        // Reset mid-stream
        drive(1, 4'h7, 1, 4'hB, 0);
        tick();
        tick();
        tick();
        drive(0, 4'h0, 1, 4'hC, 0);
        tick();
        chk("mid_pre_empty", {bus.empty1, bus.empty0}, 2'b00);
        chk("mid_pre_valid", bus.valid_out, 1);
        drive(0, 4'h0, 0, 4'h0, 0);
        #2;
        reset_L = 1'b0;
        #1;
        chk("mid_valid", bus.valid_out, 0);
        chk("mid_data", bus.data_out, 0);
        chk("mid_ovf", bus.overflow, 0);
        chk("mid_empty", {bus.empty1, bus.empty0}, 2'b11);
        reset_L = 1'b1;
        drive(0, 4'h0, 1, 4'hD, 1);
        tick();
        chk("mid_lat", bus.valid_out, 0);
        drive(0, 4'h0, 0, 4'h0, 0);
        tick();
        chk("mid_d", {bus.valid_out, bus.data_out}, 8'h1D);

        // Full with simultaneous read
        for (int i = 1; i <= 4; i++) begin
            drive(1, 4'(i), 0, 4'h0, 0);
            tick();
        end
        chk("fr_full", bus.full0, 1);
        chk("fr_noovf", bus.overflow, 0);
        drive(1, 4'h9, 0, 4'h0, 1);
        tick();
        chk("fr_read", {bus.valid_out, bus.data_out}, 8'h11);
        chk("fr_ovf", bus.overflow, 1);
        chk("fr_notfull", {bus.full0, bus.empty0}, 2'b00);
        drive(0, 4'h0, 0, 4'h0, 1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("fr_drain", {bus.valid_out, bus.data_out}, 8'(8'h10 + i));
        end
        tick();
        chk("fr_end", bus.valid_out, 0);
        chk("fr_empty0", bus.empty0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lane_merge2.md
Name: lane_merge2

Overview:
- Downstream stage of the 1-to-2 lane splitter: consumes its two 4-bit output lanes and recombines them into one serial 4-bit stream.
- Each lane has its own small FIFO. A round-robin arbiter drains the FIFOs into a registered output with a valid/ready handshake.
- Word order within a lane is preserved. Lanes are interleaved fairly.

Parameters:
- WIDTH, 4, data width of each lane and of the output.
- DEPTH, 4, entries per lane FIFO; must be a power of 2, minimum 2.
- ADDR, 2, log2(DEPTH); pointer width.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- data_in0  input  WIDTH  lane 0 word.
- valid_in0  input  1  lane 0 word present this cycle.
- data_in1  input  WIDTH  lane 1 word.
- valid_in1  input  1  lane 1 word present this cycle.
- ready_in  input  1  downstream accepts data_out this cycle.
- data_out  output  WIDTH  merged output word, registered.
- valid_out  output  1  data_out holds a valid word, registered.
- full0, full1  output  1  lane FIFO holds DEPTH words.
- empty0, empty1  output  1  lane FIFO holds 0 words.
- overflow  output  1  sticky; set when a write is dropped.

Behaviour:
- Reset (reset_L=0, asynchronous): both FIFOs flushed; pointers and counts = 0; data_out=0; valid_out=0; overflow=0; empty0=empty1=1; full0=full1=0; last_lane=1, so lane 0 wins first.
  - Reset asserted mid-operation discards all stored and pending words immediately.
  - First write is accepted on the first rising edge with reset_L=1.
- FIFO write: at each edge, lane k writes data_ink when valid_ink=1 and fullk=0.
  - valid_ink=1 while fullk=1: word dropped and overflow set to 1. overflow stays 1 until reset.
  - fullk is sampled before the edge. A write is still dropped if the same lane is read on that edge (no write-through when full).
- Counts are ADDR+1 bits wide. Pointers are ADDR bits and wrap from DEPTH-1 to 0.
  - fullk = (countk==DEPTH); emptyk = (countk==0). Both are combinational from the registered counts.
- Output load condition: load = (valid_out==0 || ready_in==1) and (empty0==0 || empty1==0).
- Lane selection on load:
  - Both lanes non-empty: read lane = ~last_lane.
  - Only one lane non-empty: read that lane.
  - last_lane updates to the lane read.
- On a load edge: data_out takes the head word of the selected lane, valid_out=1, and that lane's read pointer advances.
- No load, and ready_in=1 with valid_out=1: valid_out=0. data_out holds its last value.
- No load, and ready_in=0: data_out and valid_out hold.
- A lane may be written and read on the same edge. Its count is then unchanged and its pointers both advance.
- Latency: a word written at edge N is visible as not-empty after edge N. It can load at edge N+1, so valid_out rises after edge N+1 (1 cycle minimum, with an empty pipe and ready_in=1).
- Throughput: one word per cycle while ready_in=1 and data is available.
- Back-pressure: with ready_in=0, the FIFOs keep filling until full, then drop and set overflow.

Test Plan:
- Reset then idle: reset_L=0 for 2 cycles, then 1 with no valid inputs -> valid_out=0, data_out=0, empty0=empty1=1, overflow=0 throughout.
- Alternating merge: every cycle valid_in0=1, valid_in1=1, lane0 sends 0x1,0x3,0x5 and lane1 sends 0x2,0x4,0x6, ready_in=1 -> data_out sequence 0x1,0x2,0x3,0x4,0x5,0x6 on consecutive cycles, first valid one cycle after the first write.
- Single lane: lane1 only, sending 0xF,0x6,0x8 -> output 0xF,0x6,0x8 in order. The arbiter never stalls waiting on the empty lane0.
- Back-pressure and overflow: ready_in=0 with data_out=0xA already valid; lane0 writes 0x1..0x5 (DEPTH=4) -> full0=1 after the 4th write, 0x5 dropped, overflow=1, data_out stays 0xA. Then ready_in=1 -> output 0xA,0x1,0x2,0x3,0x4. empty0=1 afterwards; overflow remains 1.
- Reset mid-stream: both FIFOs holding 3 words, reset_L pulsed low between clock edges -> valid_out, data_out and overflow drop to 0 immediately, empty0=empty1=1. After release, new word 0xD on lane1 appears as data_out=0xD one cycle later.
- Full-with-simultaneous-read: lane0 full, ready_in=1, valid_in0=1 with 0x9 -> one word read out, 0x9 dropped, overflow=1, count0=3 after the edge.
